// File: rtl/gray_updown_counter_if.sv
// Bundle of the counter's event inputs and count/status outputs.
// Handshake: no valid/ready; every input is sampled level-wise each clock, pulse is fully asynchronous.
interface gray_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             pulse;
    logic             en;
    logic             dir;
    logic             clr;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] bin;
    logic             wrap;
    logic             sat;

    modport master (output pulse, en, dir, clr, input count, bin, wrap, sat);
    modport slave  (input pulse, en, dir, clr, output count, bin, wrap, sat);
endinterface

// File: rtl/gray_updown_counter.sv
// Up/down Gray counter fed by an asynchronous pulse through a synchroniser.
// Define GRAYCNT_SAT_EN to saturate at the terminal values instead of wrapping.
module gray_updown_counter #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input logic                  clk,
    input logic                  rst,
    gray_updown_counter_if.slave bus
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic [SYNC_STAGES:0]   primed;
    logic                   sync_out;
    logic                   evt;
    logic                   qual;
    logic [WIDTH-1:0]       bin_q;
    logic [WIDTH-1:0]       bin_nxt;
    logic [WIDTH-1:0]       count_q;
    logic                   wrap_q;
    logic                   wrap_nxt;
`ifdef GRAYCNT_SAT_EN
    logic                   sat_q;
    logic                   sat_nxt;
`endif

    // The history register keeps sampling while en=0 or clr=1, so masked edges are lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync   <= '0;
            hist   <= 1'b0;
            primed <= '0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], bus.pulse};
            hist   <= sync_out;
            primed <= {primed[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sync_out = sync[SYNC_STAGES-1];
    assign evt      = (EDGE_MODE == 0) ? (sync_out & ~hist) : (sync_out ^ hist);
    // Events stay masked until the chain and history have both seen the post-reset pulse level,
    // so a level already present at reset release is absorbed rather than counted.
    assign qual     = evt & bus.en & ~bus.clr & primed[SYNC_STAGES];

    always_comb begin
        bin_nxt  = bin_q;
        wrap_nxt = 1'b0;
`ifdef GRAYCNT_SAT_EN
        sat_nxt  = 1'b0;
`endif
        if (bus.clr) begin
            bin_nxt = '0;
        end else if (qual) begin
            if (bus.dir) begin
                if (bin_q == {WIDTH{1'b1}}) begin
`ifdef GRAYCNT_SAT_EN
                    sat_nxt  = 1'b1;
`else
                    bin_nxt  = '0;
                    wrap_nxt = 1'b1;
`endif
                end else begin
                    bin_nxt = bin_q + WIDTH'(1);
                end
            end else begin
                if (bin_q == '0) begin
`ifdef GRAYCNT_SAT_EN
                    sat_nxt  = 1'b1;
`else
                    bin_nxt  = {WIDTH{1'b1}};
                    wrap_nxt = 1'b1;
`endif
                end else begin
                    bin_nxt = bin_q - WIDTH'(1);
                end
            end
        end
    end

    // Gray code is derived from the next binary value so both register on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q   <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            bin_q   <= bin_nxt;
            count_q <= bin_nxt ^ (bin_nxt >> 1);
            wrap_q  <= wrap_nxt;
        end
    end

`ifdef GRAYCNT_SAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_nxt;
        end
    end
    assign bus.sat = sat_q;
`else
    assign bus.sat = 1'b0;
`endif

    assign bus.count = count_q;
    assign bus.bin   = bin_q;
    assign bus.wrap  = wrap_q;
endmodule
